ln1p_series_ctrl: RTL and testbench

//  Sequences evaluation of ln(1+x) ~= sum_{k=1..N_TERMS} c(k)*x^k, where c(k) = (-1)^(k+1)/k.

---
 rtl/ln1p_series_ctrl.sv | 136 +++++++++++++
 tb/tb_ln1p_series_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ln1p_series_ctrl.sv
// Run controller for the ln(1+x) power series: sequences shared FP multiply/add units
// through N_TERMS coefficient products, keeping x, x^k and the running sum locally.
module ln1p_series_ctrl #(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  lut_n,
  input  logic [31:0] lut_coef,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        add_start,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic        add_done,
  input  logic [31:0] add_result
);

  typedef enum logic [2:0] {
    IDLE, TERM_REQ, TERM_WAIT, ADD_REQ, ADD_WAIT, POW_REQ, POW_WAIT, DONE
  } state_e;

  localparam logic [3:0] K_LAST = 4'(N_TERMS);

  state_e      state_q, state_d;
  logic [3:0]  k_q;
  logic [31:0] x_reg_q, x_pow_q, term_q, acc_q, result_q;
  logic        upd_en;

  // Abort suppresses every register update, so it also beats a same-cycle unit done.
  assign upd_en = !abort || (state_q == IDLE);
  assign lut_n  = k_q[2:0];
  assign result = result_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (start) state_d = TERM_REQ;
        TERM_REQ:  state_d = TERM_WAIT;
        TERM_WAIT: if (mul_done) state_d = ADD_REQ;
        ADD_REQ:   state_d = ADD_WAIT;
        ADD_WAIT:  if (add_done) state_d = (k_q == K_LAST) ? DONE : POW_REQ;
        POW_REQ:   state_d = POW_WAIT;
        POW_WAIT:  if (mul_done) state_d = TERM_REQ;
        DONE:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Unit dones are only honoured in their own WAIT state; strays elsewhere fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      x_reg_q  <= '0;
      x_pow_q  <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (upd_en) begin
      case (state_q)
        IDLE: if (start) begin
          x_reg_q <= x_in;
          x_pow_q <= x_in;
          acc_q   <= '0;
          k_q     <= 4'd1;
        end
        TERM_WAIT: if (mul_done) term_q <= mul_result;
        ADD_WAIT: if (add_done) begin
          acc_q <= add_result;
          // Loading the final sum here makes result valid in the DONE cycle itself.
          if (k_q == K_LAST) result_q <= add_result;
        end
        POW_WAIT: if (mul_done) begin
          x_pow_q <= mul_result;
          k_q     <= k_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    add_start = 1'b0;
    add_a     = '0;
    add_b     = '0;
    case (state_q)
      TERM_REQ, TERM_WAIT: begin
        busy      = 1'b1;
        mul_start = (state_q == TERM_REQ);
        mul_a     = x_pow_q;
        mul_b     = lut_coef;
      end
      ADD_REQ, ADD_WAIT: begin
        busy      = 1'b1;
        add_start = (state_q == ADD_REQ);
        add_a     = acc_q;
        add_b     = term_q;
      end
      POW_REQ, POW_WAIT: begin
        busy      = 1'b1;
        mul_start = (state_q == POW_REQ);
        mul_a     = x_pow_q;
        mul_b     = x_reg_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ln1p_series_ctrl.sv
// Self-checking bench for ln1p_series_ctrl: behavioural FP units and coefficient LUT,
// a scoreboard of golden sums, and directed cycle-count, abort and reset scenarios.
module tb_ln1p_series_ctrl;

  logic        clk, rst_n, start, abort;
  logic [31:0] x_in, result, lut_coef;
  logic        busy, done, mul_start, add_start, mul_done, add_done;
  logic [2:0]  lut_n;
  logic [31:0] mul_a, mul_b, mul_result, add_a, add_b, add_result;

  ln1p_series_ctrl #(.N_TERMS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_in(x_in),
    .busy(busy), .done(done), .result(result), .lut_n(lut_n), .lut_coef(lut_coef),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done),
    .mul_result(mul_result), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_result(add_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0, n_miss = 0, spurious = 0;
  int          mul_lat = 1, add_lat = 1;
  bit          chk_stable = 1'b0;
  logic [31:0] lut_tbl [8];
  logic [31:0] sb [$];
  logic [2:0]  lut_log [$];
  logic [31:0] last_result = '0;

  assign lut_coef = lut_tbl[lut_n];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Simplified single-precision conversion (truncating, normal numbers and zero).
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  m;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Straight software evaluation of the series using the same unit models.
  function automatic logic [31:0] golden(input logic [31:0] x);
    logic [31:0] xp, acc;
    xp  = x;
    acc = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      acc = fadd(acc, fmul(xp, lut_tbl[k % 8]));
      if (k < 8) xp = fmul(xp, x);
    end
    return acc;
  endfunction

  always begin : mul_unit
    logic [31:0] a, b;
    int          lat;
    @(negedge clk);
    if (mul_start) begin
      a   = mul_a;
      b   = mul_b;
      lat = (mul_lat == 0) ? $urandom_range(1, 10) : mul_lat;
      for (int i = 0; i < lat; i++) begin
        @(posedge clk);
        #1;
        if (chk_stable) begin
          check("mul_a_stable", mul_a, a);
          check("mul_b_stable", mul_b, b);
        end
      end
      mul_result = fmul(a, b);
      mul_done   = 1'b1;
      @(posedge clk);
      #1 mul_done = 1'b0;
    end
  end

  always begin : add_unit
    logic [31:0] a, b;
    int          lat;
    @(negedge clk);
    if (add_start) begin
      a   = add_a;
      b   = add_b;
      lat = (add_lat == 0) ? $urandom_range(1, 10) : add_lat;
      for (int i = 0; i < lat; i++) begin
        @(posedge clk);
        #1;
        if (chk_stable) begin
          check("add_a_stable", add_a, a);
          check("add_b_stable", add_b, b);
        end
      end
      add_result = fadd(a, b);
      add_done   = 1'b1;
      @(posedge clk);
      #1 add_done = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    if (add_start) lut_log.push_back(lut_n);
    if (done) begin
      check("busy_in_done", 32'(busy), 32'd0);
      if (sb.size() == 0) begin
        spurious++;
      end else begin
        last_result = sb.pop_front();
        check("result", result, last_result);
      end
    end
  end

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic launch(input logic [31:0] x, input bit expect_done);
    @(negedge clk);
    x_in  = x;
    start = 1'b1;
    if (expect_done) sb.push_back(golden(x));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run(input logic [31:0] x, output int n);
    launch(x, 1'b1);
    wait_done(n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {27'd0, busy, done, mul_start, add_start, 1'b0}, 32'd0);
    check({tag, "_lut_n"}, 32'(lut_n), 32'd0);
    check({tag, "_mul_ab"}, mul_a | mul_b, 32'd0);
    check({tag, "_add_ab"}, add_a | add_b, 32'd0);
    check({tag, "_result"}, result, 32'd0);
  endtask

  localparam logic [31:0] HALF = 32'h3F00_0000;

  initial begin : main
    int n, tot, cnt, guard;
    bit saw_done, saw_busy;
    logic [31:0] prev;
    for (int k = 0; k < 8; k++) begin
      int kk;
      kk = (k == 0) ? 8 : k;
      lut_tbl[k] = r2f(((kk % 2) == 1 ? 1.0 : -1.0) / real'(kk));
    end
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; x_in = '0;
    mul_done = 1'b0; add_done = 1'b0; mul_result = '0; add_result = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // x = 0: fixed 1-cycle units give done in the 47th cycle after acceptance
    run(32'h0, n);
    check("cycles_x0", 32'(n), 32'd47);

    // x = 0.5: coefficient index sequence and approximate value
    lut_log.delete();
    run(HALF, n);
    check("cycles_half", 32'(n), 32'd47);
    check("lut_count", 32'(lut_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < lut_log.size(); i++)
      check("lut_seq", 32'(lut_log[i]), 32'((i + 1) % 8));
    check("approx_ln1p5", 32'(f2r(result) > 0.4052 && f2r(result) < 0.4054), 32'd1);

    // random latencies, operands checked for stability through every WAIT
    mul_lat = 0; add_lat = 0; chk_stable = 1'b1;
    run(HALF, n);
    for (int i = 0; i < 3; i++) begin
      real xr;
      xr = real'($urandom_range(1, 1800)) / 1000.0 - 0.9;
      run(r2f(xr), n);
    end
    mul_lat = 1; add_lat = 1; chk_stable = 1'b0;

    // start pulse mid-run is ignored: latency and result unchanged
    launch(HALF, 1'b1);
    repeat (9) @(negedge clk);
    x_in  = r2f(0.9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("cycles_start_busy", 32'(10 + n), 32'd47);

    // start held high through DONE: next run only accepted from IDLE
    @(negedge clk);
    x_in  = HALF;
    start = 1'b1;
    sb.push_back(golden(HALF));
    @(negedge clk);
    wait_done(n);
    check("cycles_held_start", 32'(n), 32'd47);
    sb.push_back(golden(HALF));
    @(negedge clk);
    check("busy_idle_after_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("busy_rerun", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(n);
    check("cycles_rerun", 32'(n), 32'd47);

    // abort in ADD_WAIT with the add completing one cycle later
    add_lat = 2;
    prev    = last_result;
    launch(r2f(0.25), 1'b0);
    guard = 0;
    while (!add_start && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("add_req_seen", 32'(add_start), 32'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_done |= done;
      saw_busy |= busy;
      @(negedge clk);
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_idle", 32'(saw_busy), 32'd0);
    check("abort_result_kept", result, prev);
    add_lat = 1;

    // reset while waiting on the power multiply; its done lands after release
    mul_lat = 4;
    launch(HALF, 1'b0);
    cnt   = mul_start ? 1 : 0;
    guard = 0;
    while (cnt < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (mul_start) cnt++;
    end
    check("pow_req_seen", 32'(cnt), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);
    check_reset_outputs("midrun_reset");
    mul_lat = 1;
    repeat (4) @(negedge clk);
    run(r2f(-0.3), tot);
    check("cycles_after_reset", 32'(tot), 32'd47);

    repeat (4) @(negedge clk);
    check("no_spurious_done", 32'(spurious), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
